// File: rtl/nr_mul_seq.sv
// Sequential signed multiplier: radix-2 shift-add on operand magnitudes, one
// multiplier bit per clock, sign applied and optional arithmetic shift on completion.
module nr_mul_seq #(
    parameter int QW    = 32,
    parameter int DW    = 16,
    parameter int SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [QW-1:0]    q_in,
    input  logic [DW-1:0]    d_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW+DW-1:0] p_out,
    output logic             busy
);

    localparam int PW = QW + DW;
    localparam int CW = (DW > 1) ? $clog2(DW) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [DW-1:0] mcand_q,  mcand_d;
    logic [QW-1:0] mplier_q, mplier_d;
    logic [PW-1:0] acc_q,    acc_d;
    logic          sign_q,   sign_d;
    logic [PW-1:0] p_q,      p_d;
    logic          ov_q,     ov_d;

    logic [QW-1:0]        q_mag;
    logic [DW-1:0]        d_mag;
    logic [PW-1:0]        partial;
    logic [PW-1:0]        acc_next;
    logic [PW-1:0]        signed_prod;
    logic signed [PW-1:0] signed_prod_s;
    logic [PW-1:0]        shifted;

    // Magnitude of the most-negative input is its own bit pattern read as unsigned.
    always_comb begin
        q_mag         = q_in[QW-1] ? -q_in : q_in;
        d_mag         = d_in[DW-1] ? -d_in : d_in;
        partial       = PW'(mplier_q) << cnt_q;
        acc_next      = mcand_q[0] ? (acc_q + partial) : acc_q;
        signed_prod   = sign_q ? -acc_next : acc_next;
        signed_prod_s = signed_prod;
        shifted       = signed_prod_s >>> SHIFT;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        sign_d   = sign_q;
        p_d      = p_q;
        ov_d     = ov_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    mplier_d = q_mag;
                    mcand_d  = d_mag;
                    sign_d   = q_in[QW-1] ^ d_in[DW-1];
                    cnt_d    = '0;
                    acc_d    = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                acc_d   = acc_next;
                mcand_d = mcand_q >> 1;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    p_d     = shifted;
                    ov_d    = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    ov_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                ov_d    = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            sign_q   <= 1'b0;
            p_q      <= '0;
            ov_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            sign_q   <= sign_d;
            p_q      <= p_d;
            ov_q     <= ov_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_RUN) || (state_q == S_DONE);
    assign out_valid = ov_q;
    assign p_out     = p_q;

endmodule

// File: tb/tb_nr_mul_seq.sv
// Scoreboard bench for nr_mul_seq: two instances (SHIFT=0 and SHIFT=14) checked
// against a plain signed-multiply reference with latency, stability and reset checks.
module tb_nr_mul_seq;

    typedef struct {
        logic [47:0] p;
        int          acc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [31:0] q_s  [2];
    logic [15:0] d_s  [2];
    logic        iv   [2];
    logic        ir   [2];
    logic        ov   [2];
    logic        orr  [2];
    logic        bz   [2];
    logic [47:0] p_s  [2];

    exp_t sb0[$];
    exp_t sb1[$];

    int tests   = 0;
    int failed  = 0;
    int cycle   = 0;
    int bp_mode = 0;
    int hold    [2];

    logic        prev_v  [2];
    logic        prev_r  [2];
    logic        prev_hs [2];
    logic [47:0] prev_p  [2];

    nr_mul_seq #(.QW(32), .DW(16), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
        .q_in(q_s[0]), .d_in(d_s[0]), .out_valid(ov[0]), .out_ready(orr[0]),
        .p_out(p_s[0]), .busy(bz[0])
    );

    nr_mul_seq #(.QW(32), .DW(16), .SHIFT(14)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
        .q_in(q_s[1]), .d_in(d_s[1]), .out_valid(ov[1]), .out_ready(orr[1]),
        .p_out(p_s[1]), .busy(bz[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [47:0] model(logic [31:0] q, logic [15:0] d, int sh);
        longint prod;
        prod = longint'($signed(q)) * longint'($signed(d));
        prod = prod >>> sh;
        return prod[47:0];
    endfunction

    task automatic chk(string nm, logic [63:0] act, logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    // Present operands and hold in_valid until the instance is ready; record the expectation.
    task automatic issue(int k, logic [31:0] q, logic [15:0] d);
        int   n;
        exp_t e;
        n = 0;
        @(posedge clk); #1;
        q_s[k] = q;
        d_s[k] = d;
        iv[k]  = 1'b1;
        while (!ir[k] && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (!ir[k]) begin
            tests++;
            failed++;
            $display("FAIL accept_timeout: dut%0d in_ready stuck 0, required 1", k);
            iv[k] = 1'b0;
            return;
        end
        e.p   = model(q, d, (k == 0) ? 0 : 14);
        e.acc = cycle + 1;
        if (k == 0) sb0.push_back(e);
        else        sb1.push_back(e);
        @(posedge clk); #1;
        iv[k]  = 1'b0;
        q_s[k] = $urandom;
        d_s[k] = 16'($urandom);
    endtask

    task automatic junk(int k);
        @(posedge clk); #1;
        if (!ir[k]) begin
            q_s[k] = $urandom;
            d_s[k] = 16'($urandom);
            iv[k]  = 1'b1;
            @(posedge clk); #1;
            iv[k]  = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb0.size() != 0 || sb1.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (sb0.size() != 0 || sb1.size() != 0) begin
            tests++;
            failed++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb0.size() + sb1.size());
        end
        repeat (2) @(posedge clk);
    endtask

    // Downstream ready: 0 = always ready, 1 = random backpressure, 2 = hold off 5 cycles per result.
    initial begin
        orr[0] = 1'b0; orr[1] = 1'b0;
        hold[0] = 0;   hold[1] = 0;
        forever begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                case (bp_mode)
                    0: orr[k] = 1'b1;
                    1: orr[k] = ($urandom_range(0, 2) != 0);
                    default: begin
                        if (ov[k]) begin
                            if (hold[k] < 5) begin
                                orr[k] = 1'b0;
                                hold[k]++;
                            end else begin
                                orr[k] = 1'b1;
                            end
                        end else begin
                            hold[k] = 0;
                            orr[k]  = 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            exp_t head;
            int   qs;
            if (rst) begin
                prev_v[k]  = 1'b0;
                prev_r[k]  = 1'b0;
                prev_hs[k] = 1'b0;
                prev_p[k]  = '0;
            end else begin
                qs = (k == 0) ? sb0.size() : sb1.size();
                chk("in_ready_vs_busy", 64'(ir[k]), 64'(!bz[k]));
                if (prev_hs[k]) chk("valid_drop_after_handshake", 64'(ov[k]), 64'd0);
                if (prev_v[k] && !prev_r[k]) begin
                    chk("valid_held", 64'(ov[k]), 64'd1);
                    chk("p_out_held", 64'(p_s[k]), 64'(prev_p[k]));
                end
                if (ov[k] && !prev_v[k]) begin
                    if (qs == 0) begin
                        chk("unexpected_output", 64'(ov[k]), 64'd0);
                    end else begin
                        head = (k == 0) ? sb0[0] : sb1[0];
                        chk("latency", 64'(cycle - head.acc), 64'd16);
                    end
                end
                if (ov[k] && orr[k] && qs != 0) begin
                    if (k == 0) head = sb0.pop_front();
                    else        head = sb1.pop_front();
                    chk((k == 0) ? "product_shift0" : "product_shift14", 64'(p_s[k]), 64'(head.p));
                end
                prev_hs[k] = ov[k] && orr[k];
                prev_v[k]  = ov[k];
                prev_r[k]  = orr[k];
                prev_p[k]  = p_s[k];
            end
        end
    end

    initial begin
        logic [31:0] q;
        logic [15:0] d;
        logic [31:0] qpick [5];
        logic [15:0] dpick [5];
        qpick[0] = 32'h0;        qpick[1] = 32'h80000000; qpick[2] = 32'h7FFFFFFF;
        qpick[3] = 32'hFFFFFFFF; qpick[4] = 32'h1;
        dpick[0] = 16'h0;        dpick[1] = 16'h8000;     dpick[2] = 16'h7FFF;
        dpick[3] = 16'hFFFF;     dpick[4] = 16'h1;

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; q_s[k] = '0; d_s[k] = '0;
        end
        #23;
        for (int k = 0; k < 2; k++) begin
            chk("reset_out_valid", 64'(ov[k]), 64'd0);
            chk("reset_p_out",     64'(p_s[k]), 64'd0);
            chk("reset_busy",      64'(bz[k]), 64'd0);
            chk("reset_in_ready",  64'(ir[k]), 64'd1);
        end
        rst = 1'b0;

        bp_mode = 0;
        issue(0, 32'd3, 16'd5);
        issue(0, -32'sd7, 16'd3);
        issue(0, 32'h80000000, 16'h8000);
        issue(0, 32'h12345678, 16'h0);
        issue(0, 32'h0, 16'hFFFF);
        issue(0, 32'h7FFFFFFF, 16'h8000);
        issue(1, 32'h40000000, 16'h2000);
        issue(1, 32'hFFFFFFFF, 16'h0001);
        issue(1, 32'h80000000, 16'h8000);
        drain();

        bp_mode = 2;
        issue(0, 32'hDEADBEEF, 16'h1234);
        repeat (24) junk(0);
        issue(0, 32'h00000011, 16'hFFF0);
        repeat (6) junk(0);
        issue(1, 32'hC0000000, 16'h6000);
        drain();

        bp_mode = 0;
        issue(0, 32'h0BADF00D, 16'h7777);
        repeat (8) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("abort_out_valid", 64'(ov[0]), 64'd0);
        chk("abort_p_out",     64'(p_s[0]), 64'd0);
        chk("abort_busy",      64'(bz[0]), 64'd0);
        chk("abort_in_ready",  64'(ir[0]), 64'd1);
        sb0.delete();
        #8 rst = 1'b0;
        issue(0, 32'd2, 16'd2);
        drain();

        bp_mode = 1;
        for (int i = 0; i < 2000; i++) begin
            q = $urandom;
            d = 16'($urandom);
            if ($urandom_range(0, 7) == 0) q = qpick[$urandom_range(0, 4)];
            if ($urandom_range(0, 7) == 0) d = dpick[$urandom_range(0, 4)];
            issue((i % 8 == 7) ? 1 : 0, q, d);
        end
        bp_mode = 0;
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "timeout");
    end

endmodule
